// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle microcoded control sequencer for the tiny16 ISA.
// Interrupt support is compiled in only when `CTRL_SEQ_IRQ_EN is defined.
module ctrl_seq #(
    parameter int DATA_W  = 16,
    parameter int STEP_W  = 3,
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in,
    input  logic [3:0]        flags,
    input  logic              run,
`ifdef CTRL_SEQ_IRQ_EN
    input  logic              irq,
`endif
    output logic [3:0]        alu_opcode,
    output logic [3:0]        reg_src_sel,
    output logic [3:0]        reg_dst_sel,
    output logic [15:0]       ctl_bus,
    output logic [DATA_W-1:0] out,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH_A, S_FETCH_R, S_DECODE, S_EXEC, S_HALT
`ifdef CTRL_SEQ_IRQ_EN
        , S_IRQ
`endif
    } state_e;

    localparam logic [15:0] E_ALU_OUT  = 16'h0001;
    localparam logic [15:0] E_MEM_ADDR = 16'h0002;
    localparam logic [15:0] E_MEM_IN   = 16'h0004;
    localparam logic [15:0] E_MEM_OUT  = 16'h0008;
    localparam logic [15:0] E_REG_IN   = 16'h0010;
    localparam logic [15:0] E_REG_UP   = 16'h0020;
    localparam logic [15:0] E_REG_LO   = 16'h0040;
    localparam logic [15:0] E_PC_INC   = 16'h0080;
    localparam logic [15:0] E_SP_INC   = 16'h0100;
    localparam logic [15:0] E_SP_DEC   = 16'h0200;
    localparam logic [15:0] E_REG_OUT  = 16'h0400;
    localparam logic [15:0] E_CTL_OUT  = 16'h0800;
    localparam logic [15:0] E_DSP_IN   = 16'h1000;
`ifdef CTRL_SEQ_IRQ_EN
    localparam logic [15:0] E_IRQ_ACK  = 16'h2000;
`endif

    localparam logic [3:0] R_PC  = 4'd1;
    localparam logic [3:0] R_SP  = 4'd2;
    localparam logic [3:0] R_BA  = 4'd3;
    localparam logic [3:0] R_RA  = 4'd4;
    localparam logic [3:0] R_RES = 4'd15;

    localparam logic [3:0] OP_SYS  = 4'd0;
    localparam logic [3:0] OP_OUT  = 4'd1;
    localparam logic [3:0] OP_LLI  = 4'd2;
    localparam logic [3:0] OP_LUI  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_PUSH = 4'd10;
    localparam logic [3:0] OP_POP  = 4'd11;
    localparam logic [3:0] OP_JALR = 4'd12;
    localparam logic [3:0] OP_BR   = 4'd13;

    localparam logic [STEP_W-1:0] ST0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] ST1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] ST2 = STEP_W'(2);

    state_e            state_q;
    logic [STEP_W-1:0] step_q;
    logic [15:0]       inst_q;
`ifdef CTRL_SEQ_IRQ_EN
    logic              ie_q;
`endif

    logic [3:0] opc, funct, dst, src, alu_fn;
    logic       imm, ind, is_alu, is_hlt, br_take;
    logic [STEP_W-1:0] last_step;
    logic [DATA_W-1:0] imm_val;

    assign opc     = inst_q[15:12];
    assign funct   = inst_q[11:8];
    assign imm     = inst_q[9];
    assign ind     = inst_q[8];
    assign dst     = inst_q[7:4];
    assign src     = inst_q[3:0];
    assign is_alu  = (inst_q[15:14] == 2'b01);
    assign alu_fn  = {inst_q[13:12], inst_q[11:10]};
    assign is_hlt  = (opc == OP_SYS) && (funct == 4'hF);
    // funct[2:1] picks the flag, funct[0] inverts it; funct >= 8 never branches
    assign br_take = !funct[3] && (flags[funct[2:1]] ^ funct[0]);
    assign imm_val = is_alu ? DATA_W'(inst_q[3:0]) : DATA_W'(inst_q[7:0]);

    always_comb begin
        last_step = ST0;
        if (is_alu) begin
            if (imm)      last_step = ST1;
            else if (ind) last_step = ST2;
        end else begin
            case (opc)
                OP_OUT, OP_LD, OP_ST:  last_step = ind ? ST1 : ST0;
                OP_PUSH, OP_POP:       last_step = ST2;
                OP_JALR, OP_BR:        last_step = ST1;
                default:               last_step = ST0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH_A;
            step_q  <= '0;
            inst_q  <= '0;
`ifdef CTRL_SEQ_IRQ_EN
            ie_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH_A: begin
`ifdef CTRL_SEQ_IRQ_EN
                    if (irq && ie_q) state_q <= S_IRQ;
                    else             state_q <= S_FETCH_R;
`else
                    state_q <= S_FETCH_R;
`endif
                end
                S_FETCH_R: state_q <= S_DECODE;
                S_DECODE: begin
                    inst_q  <= in[15:0];
                    step_q  <= '0;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (step_q == last_step) begin
                        step_q  <= '0;
                        state_q <= is_hlt ? S_HALT : S_FETCH_A;
`ifdef CTRL_SEQ_IRQ_EN
                        if (opc == OP_SYS && funct == 4'd3) ie_q <= 1'b1;
                        if (opc == OP_SYS && funct == 4'd4) ie_q <= 1'b0;
`endif
                    end else begin
                        step_q <= step_q + ST1;
                    end
                end
                S_HALT: begin
`ifdef CTRL_SEQ_IRQ_EN
                    if (run || (irq && ie_q)) state_q <= S_FETCH_A;
`else
                    if (run) state_q <= S_FETCH_A;
`endif
                end
`ifdef CTRL_SEQ_IRQ_EN
                S_IRQ: begin
                    if (step_q == ST0) begin
                        step_q <= ST1;
                    end else begin
                        step_q  <= '0;
                        ie_q    <= 1'b0;
                        state_q <= S_FETCH_A;
                    end
                end
`endif
                default: state_q <= S_FETCH_A;
            endcase
        end
    end

    logic [3:0]        alu_d, src_d, dst_d;
    logic [15:0]       ctl_d;
    logic [DATA_W-1:0] out_d;
    logic [STEP_W-1:0] step_d;
    logic              halted_d;

    always_comb begin
        alu_d    = '0;
        src_d    = '0;
        dst_d    = '0;
        ctl_d    = '0;
        out_d    = '0;
        step_d   = '0;
        halted_d = 1'b0;
        case (state_q)
            S_FETCH_A: begin
                src_d = R_PC;
                ctl_d = E_REG_OUT | E_MEM_ADDR;
            end
            S_FETCH_R: ctl_d = E_MEM_OUT | E_PC_INC;
            S_EXEC: begin
                step_d = step_q;
                out_d  = imm_val;
                if (is_alu) begin
                    // immediate and memory operands are staged through RES
                    if (imm && step_q == ST0) begin
                        dst_d = R_RES;
                        ctl_d = E_CTL_OUT | E_REG_IN;
                    end else if (!imm && ind && step_q == ST0) begin
                        src_d = src;
                        ctl_d = E_REG_OUT | E_MEM_ADDR;
                    end else if (!imm && ind && step_q == ST1) begin
                        dst_d = R_RES;
                        ctl_d = E_MEM_OUT | E_REG_IN;
                    end else begin
                        alu_d = alu_fn;
                        src_d = (imm || ind) ? R_RES : src;
                        dst_d = dst;
                        ctl_d = E_ALU_OUT | E_REG_IN;
                    end
                end else begin
                    case (opc)
                        OP_OUT: begin
                            if (ind && step_q == ST1) begin
                                ctl_d = E_MEM_OUT | E_DSP_IN;
                            end else begin
                                src_d = src;
                                ctl_d = E_REG_OUT | (ind ? E_MEM_ADDR : E_DSP_IN);
                            end
                        end
                        OP_LLI: begin
                            dst_d = R_BA;
                            ctl_d = E_CTL_OUT | E_REG_LO;
                        end
                        OP_LUI: begin
                            dst_d = R_BA;
                            ctl_d = E_CTL_OUT | E_REG_UP;
                        end
                        OP_LD: begin
                            if (!ind) begin
                                src_d = src;
                                dst_d = dst;
                                ctl_d = E_REG_OUT | E_REG_IN;
                            end else if (step_q == ST0) begin
                                src_d = src;
                                ctl_d = E_REG_OUT | E_MEM_ADDR;
                            end else begin
                                dst_d = dst;
                                ctl_d = E_MEM_OUT | E_REG_IN;
                            end
                        end
                        OP_ST: begin
                            if (ind && step_q == ST0) begin
                                src_d = dst;
                                ctl_d = E_REG_OUT | E_MEM_ADDR;
                            end else begin
                                src_d = src;
                                ctl_d = E_REG_OUT | E_MEM_IN;
                            end
                        end
                        OP_PUSH: begin
                            if (step_q == ST0) begin
                                ctl_d = E_SP_DEC;
                            end else if (step_q == ST1) begin
                                src_d = R_SP;
                                ctl_d = E_REG_OUT | E_MEM_ADDR;
                            end else begin
                                src_d = src;
                                ctl_d = E_REG_OUT | E_MEM_IN;
                            end
                        end
                        OP_POP: begin
                            if (step_q == ST0) begin
                                src_d = R_SP;
                                ctl_d = E_REG_OUT | E_MEM_ADDR;
                            end else if (step_q == ST1) begin
                                dst_d = dst;
                                ctl_d = E_MEM_OUT | E_REG_IN;
                            end else begin
                                ctl_d = E_SP_INC;
                            end
                        end
                        OP_JALR: begin
                            src_d = (step_q == ST0) ? R_PC : src;
                            dst_d = (step_q == ST0) ? R_RA : R_PC;
                            ctl_d = E_REG_OUT | E_REG_IN;
                        end
                        OP_BR: begin
                            if (step_q == ST1 && br_take) begin
                                src_d = R_BA;
                                dst_d = R_PC;
                                ctl_d = E_REG_OUT | E_REG_IN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: halted_d = 1'b1;
`ifdef CTRL_SEQ_IRQ_EN
            S_IRQ: begin
                step_d = step_q;
                if (step_q == ST0) begin
                    src_d = R_PC;
                    dst_d = R_RA;
                    ctl_d = E_REG_OUT | E_REG_IN;
                end else begin
                    dst_d = R_PC;
                    out_d = DATA_W'(16'h0008);
                    ctl_d = E_CTL_OUT | E_REG_IN | E_IRQ_ACK;
                end
            end
`endif
            default: ;
        endcase
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [3:0]        alu_q, src_q, dst_q;
            logic [15:0]       ctl_q;
            logic [DATA_W-1:0] out_q;
            logic [STEP_W-1:0] step_q2;
            logic              halted_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    alu_q    <= '0;
                    src_q    <= '0;
                    dst_q    <= '0;
                    ctl_q    <= '0;
                    out_q    <= '0;
                    step_q2  <= '0;
                    halted_q <= 1'b0;
                end else begin
                    alu_q    <= alu_d;
                    src_q    <= src_d;
                    dst_q    <= dst_d;
                    ctl_q    <= ctl_d;
                    out_q    <= out_d;
                    step_q2  <= step_d;
                    halted_q <= halted_d;
                end
            end

            assign alu_opcode  = alu_q;
            assign reg_src_sel = src_q;
            assign reg_dst_sel = dst_q;
            assign ctl_bus     = ctl_q;
            assign out         = out_q;
            assign step        = step_q2;
            assign halted      = halted_q;
        end else begin : g_ocomb
            // state sits at FETCH_A during reset, so mask its enables
            assign alu_opcode  = rst ? '0 : alu_d;
            assign reg_src_sel = rst ? '0 : src_d;
            assign reg_dst_sel = rst ? '0 : dst_d;
            assign ctl_bus     = rst ? '0 : ctl_d;
            assign out         = rst ? '0 : out_d;
            assign step        = rst ? '0 : step_d;
            assign halted      = rst ? 1'b0 : halted_d;
        end
    endgenerate

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq (OUT_REG=1): expected per-cycle control words are
// queued with the stimulus and compared each cycle on the falling edge.
module tb_ctrl_seq;

    localparam logic [15:0] E_ALU_OUT  = 16'h0001;
    localparam logic [15:0] E_MEM_ADDR = 16'h0002;
    localparam logic [15:0] E_MEM_IN   = 16'h0004;
    localparam logic [15:0] E_MEM_OUT  = 16'h0008;
    localparam logic [15:0] E_REG_IN   = 16'h0010;
    localparam logic [15:0] E_REG_UP   = 16'h0020;
    localparam logic [15:0] E_REG_LO   = 16'h0040;
    localparam logic [15:0] E_PC_INC   = 16'h0080;
    localparam logic [15:0] E_SP_INC   = 16'h0100;
    localparam logic [15:0] E_SP_DEC   = 16'h0200;
    localparam logic [15:0] E_REG_OUT  = 16'h0400;
    localparam logic [15:0] E_CTL_OUT  = 16'h0800;
    localparam logic [15:0] E_DSP_IN   = 16'h1000;
    localparam logic [15:0] E_IRQ_ACK  = 16'h2000;

    typedef struct packed {
        logic [3:0]  alu;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [15:0] ctl;
        logic [15:0] out;
        logic [2:0]  step;
        logic        halted;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic        set_in;
        logic [15:0] in_val;
        logic        run_nx;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_r;
    logic [3:0]  flags;
    logic        run_r;
    logic        irq_r;
    logic [3:0]  alu_opcode, reg_src_sel, reg_dst_sel;
    logic [15:0] ctl_bus, out_w;
    logic [2:0]  step_w;
    logic        halted;

    int   nvec  = 0;
    int   nfail = 0;
    ent_t sb[$];
    ent_t e;
    vec_t obs;

    always #5 clk = ~clk;

    ctrl_seq #(.DATA_W(16), .STEP_W(3), .OUT_REG(1)) dut (
        .clk(clk), .rst(rst), .in(in_r), .flags(flags), .run(run_r),
`ifdef CTRL_SEQ_IRQ_EN
        .irq(irq_r),
`endif
        .alu_opcode(alu_opcode), .reg_src_sel(reg_src_sel), .reg_dst_sel(reg_dst_sel),
        .ctl_bus(ctl_bus), .out(out_w), .step(step_w), .halted(halted)
    );

    assign obs = {alu_opcode, reg_src_sel, reg_dst_sel, ctl_bus, out_w, step_w, halted};

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] s, input logic [3:0] d,
                                input logic [15:0] c, input logic [15:0] o,
                                input logic [2:0] st, input logic h);
        vec_t v;
        v.alu = a; v.src = s; v.dst = d; v.ctl = c; v.out = o; v.step = st; v.halted = h;
        return v;
    endfunction

    task automatic push(input vec_t v, input logic si, input logic [15:0] iv, input logic rn);
        ent_t x;
        x.v = v; x.set_in = si; x.in_val = iv; x.run_nx = rn;
        sb.push_back(x);
    endtask

    task automatic push_fetch(input logic [15:0] instr, input logic rn);
        push(mk(4'h0, 4'h1, 4'h0, E_REG_OUT | E_MEM_ADDR, 16'h0, 3'd0, 1'b0), 1'b1, instr, rn);
        push(mk(4'h0, 4'h0, 4'h0, E_MEM_OUT | E_PC_INC, 16'h0, 3'd0, 1'b0), 1'b0, 16'h0, 1'b0);
        push(mk(4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 3'd0, 1'b0), 1'b0, 16'h0, 1'b0);
    endtask

    task automatic push_ex(input logic [3:0] a, input logic [3:0] s, input logic [3:0] d,
                           input logic [15:0] c, input logic [15:0] o, input logic [2:0] st);
        push(mk(a, s, d, c, o, st, 1'b0), 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_r = 16'h0; flags = 4'h0; run_r = 1'b0; irq_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++;
            if (obs !== 48'h0) begin
                nfail++;
                $display("FAIL reset[%0d]: got %h want 0", i, obs);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_nop;
        // run pulse outside HALT must not disturb the sequence
        push_fetch(16'h0000, 1'b1);
        push_ex(4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 3'd0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            nvec++;
            if (obs !== e.v) begin
                nfail++;
                $display("FAIL nop[%0d]: got %h want %h", nvec, obs, e.v);
            end
            if (e.set_in) in_r = e.in_val;
            run_r = e.run_nx;
        end
    endtask

    task automatic test_alu_imm;
        push_fetch(16'h4213, 1'b0);
        push_ex(4'h0, 4'h0, 4'hF, E_CTL_OUT | E_REG_IN, 16'h3, 3'd0);
        push_ex(4'h0, 4'hF, 4'h1, E_ALU_OUT | E_REG_IN, 16'h3, 3'd1);
        push_fetch(16'h7A21, 1'b0);
        push_ex(4'h0, 4'h0, 4'hF, E_CTL_OUT | E_REG_IN, 16'h1, 3'd0);
        push_ex(4'hE, 4'hF, 4'h2, E_ALU_OUT | E_REG_IN, 16'h1, 3'd1);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            nvec++;
            if (obs !== e.v) begin
                nfail++;
                $display("FAIL alu_imm[%0d]: got %h want %h", nvec, obs, e.v);
            end
            if (e.set_in) in_r = e.in_val;
            run_r = e.run_nx;
        end
    endtask

    task automatic test_br;
        logic [15:0] br_i [6] = '{16'hD000, 16'hD000, 16'hD100, 16'hD800, 16'hD700, 16'hD400};
        logic [3:0]  br_f [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b1000, 4'b0100};
        logic        br_t [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
        for (int k = 0; k < 6; k++) begin
            flags = br_f[k];
            push_fetch(br_i[k], 1'b0);
            push_ex(4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 3'd0);
            if (br_t[k]) push_ex(4'h0, 4'h3, 4'h1, E_REG_OUT | E_REG_IN, 16'h0, 3'd1);
            else         push_ex(4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 3'd1);
            while (sb.size() != 0) begin
                @(negedge clk);
                e = sb.pop_front();
                nvec++;
                if (obs !== e.v) begin
                    nfail++;
                    $display("FAIL br%0d: got %h want %h", k, obs, e.v);
                end
                if (e.set_in) in_r = e.in_val;
                run_r = e.run_nx;
            end
        end
        flags = 4'h0;
    endtask

    task automatic test_back_to_back;
        push_fetch(16'h205A, 1'b0); push_ex(0, 0, 3, E_CTL_OUT | E_REG_LO, 16'h5A, 0);
        push_fetch(16'h3012, 1'b0); push_ex(0, 0, 3, E_CTL_OUT | E_REG_UP, 16'h12, 0);
        push_fetch(16'h9145, 1'b0);
        push_ex(0, 4, 0, E_REG_OUT | E_MEM_ADDR, 16'h45, 0);
        push_ex(0, 5, 0, E_REG_OUT | E_MEM_IN,   16'h45, 1);
        push_fetch(16'h5C67, 1'b0); push_ex(7, 7, 6, E_ALU_OUT | E_REG_IN, 16'h7, 0);
        push_fetch(16'h6189, 1'b0);
        push_ex(0, 9, 0,   E_REG_OUT | E_MEM_ADDR, 16'h9, 0);
        push_ex(0, 0, 15,  E_MEM_OUT | E_REG_IN,   16'h9, 1);
        push_ex(8, 15, 8,  E_ALU_OUT | E_REG_IN,   16'h9, 2);
        push_fetch(16'hA005, 1'b0);
        push_ex(0, 0, 0, E_SP_DEC,                16'h05, 0);
        push_ex(0, 2, 0, E_REG_OUT | E_MEM_ADDR,  16'h05, 1);
        push_ex(0, 5, 0, E_REG_OUT | E_MEM_IN,    16'h05, 2);
        push_fetch(16'hB070, 1'b0);
        push_ex(0, 2, 0, E_REG_OUT | E_MEM_ADDR,  16'h70, 0);
        push_ex(0, 0, 7, E_MEM_OUT | E_REG_IN,    16'h70, 1);
        push_ex(0, 0, 0, E_SP_INC,                16'h70, 2);
        push_fetch(16'hC00A, 1'b0);
        push_ex(0, 1, 4,   E_REG_OUT | E_REG_IN, 16'h0A, 0);
        push_ex(0, 10, 1,  E_REG_OUT | E_REG_IN, 16'h0A, 1);
        push_fetch(16'h8123, 1'b0);
        push_ex(0, 3, 0, E_REG_OUT | E_MEM_ADDR, 16'h23, 0);
        push_ex(0, 0, 2, E_MEM_OUT | E_REG_IN,   16'h23, 1);
        push_fetch(16'h8045, 1'b0); push_ex(0, 5, 4, E_REG_OUT | E_REG_IN, 16'h45, 0);
        push_fetch(16'h9006, 1'b0); push_ex(0, 6, 0, E_REG_OUT | E_MEM_IN, 16'h06, 0);
        push_fetch(16'h100B, 1'b0); push_ex(0, 11, 0, E_REG_OUT | E_DSP_IN, 16'h0B, 0);
        push_fetch(16'h110C, 1'b0);
        push_ex(0, 12, 0, E_REG_OUT | E_MEM_ADDR, 16'h0C, 0);
        push_ex(0, 0, 0,  E_MEM_OUT | E_DSP_IN,   16'h0C, 1);
        push_fetch(16'hE123, 1'b0); push_ex(0, 0, 0, 16'h0, 16'h23, 0);
        push_fetch(16'h0300, 1'b0); push_ex(0, 0, 0, 16'h0, 16'h00, 0);
        push_fetch(16'h0400, 1'b0); push_ex(0, 0, 0, 16'h0, 16'h00, 0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            nvec++;
            if (obs !== e.v) begin
                nfail++;
                $display("FAIL b2b[%0d]: got %h want %h", nvec, obs, e.v);
            end
            if (e.set_in) in_r = e.in_val;
            run_r = e.run_nx;
        end
    endtask

    task automatic test_halt;
        push_fetch(16'h0F00, 1'b0);
        push_ex(0, 0, 0, 16'h0, 16'h0, 0);
        // run is raised after the 20th HALT sample, so HALT lasts one more cycle
        for (int i = 0; i < 21; i++)
            push(mk(0, 0, 0, 16'h0, 16'h0, 3'd0, 1'b1), 1'b0, 16'h0, (i == 19));
        push_fetch(16'h0000, 1'b0);
        push_ex(0, 0, 0, 16'h0, 16'h0, 0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            nvec++;
            if (obs !== e.v) begin
                nfail++;
                $display("FAIL halt[%0d]: got %h want %h", nvec, obs, e.v);
            end
            if (e.set_in) in_r = e.in_val;
            run_r = e.run_nx;
        end
    endtask

    task automatic test_rst_mid;
        push_fetch(16'hA005, 1'b0);
        push_ex(0, 0, 0, E_SP_DEC, 16'h05, 0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            nvec++;
            if (obs !== e.v) begin
                nfail++;
                $display("FAIL rst_mid[%0d]: got %h want %h", nvec, obs, e.v);
            end
            if (e.set_in) in_r = e.in_val;
            run_r = e.run_nx;
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (obs !== 48'h0) begin
            nfail++;
            $display("FAIL rst_async: got %h want 0", obs);
        end
        @(negedge clk);
        nvec++;
        if (obs !== 48'h0) begin
            nfail++;
            $display("FAIL rst_hold: got %h want 0", obs);
        end
        rst = 1'b0;
        push_fetch(16'h0000, 1'b0);
        push_ex(0, 0, 0, 16'h0, 16'h0, 0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            nvec++;
            if (obs !== e.v) begin
                nfail++;
                $display("FAIL rst_resume[%0d]: got %h want %h", nvec, obs, e.v);
            end
            if (e.set_in) in_r = e.in_val;
            run_r = e.run_nx;
        end
    endtask

`ifdef CTRL_SEQ_IRQ_EN
    task automatic test_irq;
        irq_r = 1'b1;
        push_fetch(16'h0300, 1'b0);
        push_ex(0, 0, 0, 16'h0, 16'h0, 0);
        push(mk(0, 1, 0, E_REG_OUT | E_MEM_ADDR, 16'h0, 0, 1'b0), 1'b1, 16'h0000, 1'b0);
        push_ex(0, 1, 4, E_REG_OUT | E_REG_IN, 16'h0, 0);
        push_ex(0, 0, 1, E_CTL_OUT | E_REG_IN | E_IRQ_ACK, 16'h0008, 1);
        push_fetch(16'h0000, 1'b0);
        push_ex(0, 0, 0, 16'h0, 16'h0, 0);
        push_fetch(16'h0000, 1'b0);
        push_ex(0, 0, 0, 16'h0, 16'h0, 0);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            nvec++;
            if (obs !== e.v) begin
                nfail++;
                $display("FAIL irq[%0d]: got %h want %h", nvec, obs, e.v);
            end
            if (e.set_in) in_r = e.in_val;
            run_r = e.run_nx;
        end
        irq_r = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nop();
        test_alu_imm();
        test_br();
        test_back_to_back();
        test_halt();
        test_rst_mid();
`ifdef CTRL_SEQ_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
